safe_pin_manager: RTL and testbench

SAFE_PIN_MANAGER -- requirements
Module: safe_pin_manager

---
 rtl/safe_pin_manager.sv | 110 +++++++++++
 tb/tb_safe_pin_manager.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/safe_pin_manager.sv
// safe_pin_manager: tick-qualified PIN change sequencer (enter, confirm, commit).
// Ports: clock/reset (sync, active-high); tick (1 Hz enable); unlocked (change allowed);
//        change_n/save_n (active-low buttons); switches (digit); pin (stored PIN);
//        busy/phase/cursor (sequencer status); done/fail/digit_err (one-clock pulses).
module safe_pin_manager #(
    parameter logic [15:0] DEFAULT_PIN   = 16'h4321,
    parameter int          TIMEOUT_TICKS = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        unlocked,
    input  logic        change_n,
    input  logic        save_n,
    input  logic [3:0]  switches,
    output logic [15:0] pin,
    output logic        busy,
    output logic [1:0]  phase,
    output logic [1:0]  cursor,
    output logic        done,
    output logic        fail,
    output logic        digit_err
);
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);
    typedef enum logic [1:0] {IDLE, ENTER, CONFIRM, RESULT} state_t;
    state_t        state_q;
    logic [15:0]   pin_q, new_q;
    logic [1:0]    cur_q;
    logic [CW-1:0] cnt_q;
    logic          mis_q, chg_prev_q, sav_prev_q, done_q, fail_q, derr_q;
    logic          chg_press, sav_press, valid, tmo;
    // a press is a released sample followed by a pressed sample on consecutive ticks
    assign chg_press = tick & chg_prev_q & ~change_n;
    assign sav_press = tick & sav_prev_q & ~save_n;
    assign valid     = switches <= 4'd9;
    // this tick would be the TIMEOUT_TICKS-th idle tick
    assign tmo       = cnt_q == CW'(TIMEOUT_TICKS - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pin_q      <= DEFAULT_PIN;
            new_q      <= '0;
            cur_q      <= '0;
            cnt_q      <= '0;
            mis_q      <= 1'b0;
            chg_prev_q <= 1'b1;
            sav_prev_q <= 1'b1;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            derr_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            derr_q <= 1'b0;
            if (tick) begin
                chg_prev_q <= change_n;
                sav_prev_q <= save_n;
                if (state_q == IDLE) begin
                    if (chg_press && unlocked) begin
                        state_q <= ENTER;
                        cur_q   <= '0;
                        cnt_q   <= '0;
                        mis_q   <= 1'b0;
                    end
                end else if (state_q == RESULT && !chg_press) begin
                    if (!mis_q) pin_q <= new_q;
                    done_q  <= !mis_q;
                    fail_q  <= mis_q;
                    state_q <= IDLE;
                    cur_q   <= '0;
                    mis_q   <= 1'b0;
                end else if (state_q != RESULT && !unlocked) begin
                    // losing unlock beats any save on the same tick
                    fail_q  <= 1'b1;
                    state_q <= IDLE;
                    cur_q   <= '0;
                    cnt_q   <= '0;
                    mis_q   <= 1'b0;
                end else if (chg_press) begin
                    state_q <= ENTER;
                    cur_q   <= '0;
                    cnt_q   <= '0;
                    mis_q   <= 1'b0;
                end else if (sav_press) begin
                    cnt_q <= '0;
                    if (!valid) derr_q <= 1'b1;
                    else begin
                        if (state_q == ENTER) new_q[{cur_q, 2'b00} +: 4] <= switches;
                        else if (switches != new_q[{cur_q, 2'b00} +: 4]) mis_q <= 1'b1;
                        cur_q <= cur_q + 2'd1;
                        if (cur_q == 2'd3) state_q <= (state_q == ENTER) ? CONFIRM : RESULT;
                    end
                end else if (tmo) begin
                    fail_q  <= 1'b1;
                    state_q <= IDLE;
                    cur_q   <= '0;
                    cnt_q   <= '0;
                    mis_q   <= 1'b0;
                end else cnt_q <= cnt_q + 1'b1;
            end
        end
    end
    assign pin       = pin_q;
    assign busy      = state_q != IDLE;
    assign phase     = state_q;
    assign cursor    = cur_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign digit_err = derr_q;
endmodule

// File: tb/tb_safe_pin_manager.sv
// tb_safe_pin_manager: directed-vector bench for safe_pin_manager.
module tb_safe_pin_manager;
    logic        clock = 1'b0, reset = 1'b1, tick = 1'b0, unlocked = 1'b1;
    logic        change_n = 1'b1, save_n = 1'b1;
    logic [3:0]  switches = 4'd0;
    logic [15:0] pin;
    logic        busy, done, fail, digit_err;
    logic [1:0]  phase, cursor;
    logic        pd, pf, pe;
    int          tests = 0, fails = 0;

    safe_pin_manager dut (
        .clock(clock), .reset(reset), .tick(tick), .unlocked(unlocked),
        .change_n(change_n), .save_n(save_n), .switches(switches),
        .pin(pin), .busy(busy), .phase(phase), .cursor(cursor),
        .done(done), .fail(fail), .digit_err(digit_err)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        tick  = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // one tick cycle; c/s = button pressed; pulses captured right after the edge
    task automatic tk(input logic c, input logic s, input logic [3:0] sw);
        @(negedge clock);
        change_n = ~c;
        save_n   = ~s;
        switches = sw;
        tick     = 1'b1;
        @(posedge clock);
        #1;
        pd = done;
        pf = fail;
        pe = digit_err;
        tick = 1'b0;
        change_n = 1'b1;
        save_n   = 1'b1;
    endtask

    task automatic rel();
        tk(1'b0, 1'b0, 4'd0);
    endtask

    task automatic save(input logic [3:0] d);
        tk(1'b0, 1'b1, d);
        rel();
    endtask

    task automatic start();
        tk(1'b1, 1'b0, 4'd0);
        rel();
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (pin !== 16'h4321) begin fails++; $display("FAIL reset_pin got %h exp 4321", pin); end
        tests++; if (phase !== 2'd0 || busy !== 1'b0 || cursor !== 2'd0) begin fails++; $display("FAIL reset_state got phase %0d busy %0d cursor %0d exp 0 0 0", phase, busy, cursor); end
        tests++; if ({done, fail, digit_err} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b exp 000", {done, fail, digit_err}); end
    endtask

    task automatic test_commit();
        do_reset();
        unlocked = 1'b1;
        start();
        tests++; if (phase !== 2'd1 || busy !== 1'b1) begin fails++; $display("FAIL commit_enter got phase %0d busy %0d exp 1 1", phase, busy); end
        save(4'd5); save(4'd6); save(4'd7); save(4'd8);
        tests++; if (phase !== 2'd2 || cursor !== 2'd0) begin fails++; $display("FAIL commit_confirm got phase %0d cursor %0d exp 2 0", phase, cursor); end
        save(4'd5); save(4'd6); save(4'd7);
        tk(1'b0, 1'b1, 4'd8);
        tests++; if (phase !== 2'd3 || pin !== 16'h4321) begin fails++; $display("FAIL commit_result got phase %0d pin %h exp 3 4321", phase, pin); end
        rel();
        tests++; if ({pd, pf, pe} !== 3'b100) begin fails++; $display("FAIL commit_pulse got %b exp 100", {pd, pf, pe}); end
        tests++; if (pin !== 16'h8765 || phase !== 2'd0) begin fails++; $display("FAIL commit_pin got %h phase %0d exp 8765 0", pin, phase); end
        @(posedge clock); #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL commit_pulse_width got %b exp 0", done); end
    endtask

    task automatic test_mismatch();
        do_reset();
        start();
        save(4'd5); save(4'd6); save(4'd7); save(4'd8);
        save(4'd5); save(4'd6); save(4'd9);
        tk(1'b0, 1'b1, 4'd8);
        rel();
        tests++; if ({pd, pf, pe} !== 3'b010) begin fails++; $display("FAIL mismatch_pulse got %b exp 010", {pd, pf, pe}); end
        tests++; if (pin !== 16'h4321 || phase !== 2'd0) begin fails++; $display("FAIL mismatch_pin got %h phase %0d exp 4321 0", pin, phase); end
    endtask

    task automatic test_digit_err();
        do_reset();
        start();
        save(4'd5);
        tests++; if (cursor !== 2'd1) begin fails++; $display("FAIL derr_pre got cursor %0d exp 1", cursor); end
        tk(1'b0, 1'b1, 4'd12);
        tests++; if ({pd, pf, pe} !== 3'b001 || cursor !== 2'd1) begin fails++; $display("FAIL derr_pulse got %b cursor %0d exp 001 1", {pd, pf, pe}, cursor); end
        rel();
        save(4'd3);
        tests++; if (cursor !== 2'd2 || phase !== 2'd1) begin fails++; $display("FAIL derr_recover got cursor %0d phase %0d exp 2 1", cursor, phase); end
    endtask

    task automatic test_timeout();
        logic seen;
        do_reset();
        tk(1'b1, 1'b0, 4'd0);
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tk(1'b0, 1'b0, 4'd0);
            seen = seen | pf;
        end
        tests++; if (seen !== 1'b0 || phase !== 2'd1) begin fails++; $display("FAIL timeout_early got fail %b phase %0d exp 0 1", seen, phase); end
        tk(1'b0, 1'b0, 4'd0);
        tests++; if (pf !== 1'b1 || phase !== 2'd0 || pin !== 16'h4321) begin fails++; $display("FAIL timeout_15 got fail %b phase %0d pin %h exp 1 0 4321", pf, phase, pin); end
    endtask

    task automatic test_unlock_drop();
        do_reset();
        start();
        save(4'd1); save(4'd2); save(4'd3); save(4'd4);
        save(4'd1);
        unlocked = 1'b0;
        tk(1'b0, 1'b1, 4'd2);
        unlocked = 1'b1;
        tests++; if ({pd, pf, pe} !== 3'b010 || phase !== 2'd0) begin fails++; $display("FAIL unlock_drop got %b phase %0d exp 010 0", {pd, pf, pe}, phase); end
        tests++; if (pin !== 16'h4321 || cursor !== 2'd0) begin fails++; $display("FAIL unlock_drop_pin got %h cursor %0d exp 4321 0", pin, cursor); end
    endtask

    task automatic test_locked_change();
        do_reset();
        unlocked = 1'b0;
        tk(1'b1, 1'b0, 4'd0);
        tests++; if (phase !== 2'd0 || {pd, pf, pe} !== 3'b000) begin fails++; $display("FAIL locked_change got phase %0d pulses %b exp 0 000", phase, {pd, pf, pe}); end
        rel();
        unlocked = 1'b1;
    endtask

    task automatic test_priority();
        do_reset();
        tk(1'b1, 1'b1, 4'd5);
        tests++; if (phase !== 2'd1 || cursor !== 2'd0) begin fails++; $display("FAIL chg_save_idle got phase %0d cursor %0d exp 1 0", phase, cursor); end
        rel();
        save(4'd5); save(4'd6);
        tk(1'b1, 1'b0, 4'd0);
        tests++; if (phase !== 2'd1 || cursor !== 2'd0 || {pd, pf, pe} !== 3'b000) begin fails++; $display("FAIL restart got phase %0d cursor %0d pulses %b exp 1 0 000", phase, cursor, {pd, pf, pe}); end
        rel();
    endtask

    task automatic test_reset_mid();
        do_reset();
        start();
        save(4'd5); save(4'd6); save(4'd7); save(4'd8);
        save(4'd5); save(4'd6);
        tests++; if (phase !== 2'd2 || cursor !== 2'd2) begin fails++; $display("FAIL mid_pre got phase %0d cursor %0d exp 2 2", phase, cursor); end
        do_reset();
        tests++; if (phase !== 2'd0 || cursor !== 2'd0 || pin !== 16'h4321 || busy !== 1'b0) begin fails++; $display("FAIL mid_reset got phase %0d cursor %0d pin %h busy %b exp 0 0 4321 0", phase, cursor, pin, busy); end
        save(4'd7);
        tests++; if (phase !== 2'd0 || {pd, pf, pe} !== 3'b000) begin fails++; $display("FAIL mid_after got phase %0d pulses %b exp 0 000", phase, {pd, pf, pe}); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_mismatch();
        test_digit_err();
        test_timeout();
        test_unlock_drop();
        test_locked_change();
        test_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
